// File: rtl/auto_counter_multi.sv
// -----------------------------------------------------------------------------
// auto_counter_multi
//
// Prescaled, cascaded multi-digit counter. A prescaler produces a count tick
// every g_Delay enabled cycles. On each tick a ripple chain of g_Digits digits,
// each counting 0..g_Modulus-1, advances up or down. The packed digit value
// feeds 7-segment drivers. Tick and wrap strobes support cascading and status
// LEDs.
//
// Parameters:
//   g_Delay   prescaler period in clock cycles (>= 1)
//   g_Digits  number of cascaded digits (1..8)
//   g_Width   bits per digit
//   g_Modulus per-digit modulus (2..2**g_Width)
//
// Ports:
//   i_Clk         system clock
//   i_Reset_n     asynchronous active-low reset
//   i_Enable      1 = prescaler and counter run, 0 = both frozen
//   i_Up          count direction, sampled at each tick (1 = up)
//   i_Clear       synchronous clear of prescaler and digits (highest priority)
//   i_Load        synchronous parallel load of i_Load_Value
//   i_Load_Value  load data, digit 0 in LSBs
//   o_Value       current count, digit 0 in LSBs
//   o_Tick        one-cycle pulse in the cycle after each count advance
//   o_Wrap        one-cycle pulse in the cycle after a full-counter wrap
//
// Build option:
//   AUTO_COUNTER_SATURATE_EN  when defined, the counter holds at its limit
//   instead of wrapping. o_Wrap then acts as a limit-hit flag.
// -----------------------------------------------------------------------------
module auto_counter_multi #(
    parameter int g_Delay   = 25000000,
    parameter int g_Digits  = 2,
    parameter int g_Width   = 4,
    parameter int g_Modulus = 10
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset_n,
    input  logic                          i_Enable,
    input  logic                          i_Up,
    input  logic                          i_Clear,
    input  logic                          i_Load,
    input  logic [g_Digits*g_Width-1:0]   i_Load_Value,
    output logic [g_Digits*g_Width-1:0]   o_Value,
    output logic                          o_Tick,
    output logic                          o_Wrap
);

    // A 1-bit prescaler is kept even for g_Delay = 1. It then stays at 0,
    // and every enabled cycle is a tick.
    localparam int                PW         = (g_Delay > 1) ? $clog2(g_Delay) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(g_Delay - 1);
    localparam logic [g_Width-1:0] DIGIT_MAX = g_Width'(g_Modulus - 1);
    localparam int                VW         = g_Digits * g_Width;

    logic [PW-1:0] presc_q, presc_d;
    logic [VW-1:0] value_q, value_d;
    logic          tick_q, tick_d;
    logic          wrap_q, wrap_d;

    logic          tick_w;
    logic          limit_w;     // carry or borrow out of the top digit
    logic [VW-1:0] stepped_w;   // value after one step in the current direction
    logic [VW-1:0] loaded_w;    // load data with out-of-range digits forced to 0

    assign tick_w = i_Enable && (presc_q == PRESC_LAST);

    // Sanitize each load slice independently. The compare is one bit wider so
    // that g_Modulus = 2**g_Width, where no slice is out of range, works.
    generate
        for (genvar gi = 0; gi < g_Digits; gi++) begin : g_load
            logic [g_Width-1:0] slice_w;
            assign slice_w = i_Load_Value[gi*g_Width +: g_Width];
            assign loaded_w[gi*g_Width +: g_Width] =
                ({1'b0, slice_w} >= (g_Width+1)'(g_Modulus)) ? '0 : slice_w;
        end
    endgenerate

    // Ripple chain. Each digit steps only when every lower digit rolled over.
    // The arithmetic stays inside each digit's own g_Width bits.
    always_comb begin
        logic [g_Width-1:0] digit;
        logic               carry;
        stepped_w = value_q;
        carry     = 1'b1;
        digit     = '0;
        for (int i = 0; i < g_Digits; i++) begin
            digit = value_q[i*g_Width +: g_Width];
            if (carry) begin
                if (i_Up) begin
                    if (digit == DIGIT_MAX) begin
                        digit = '0;
                    end else begin
                        digit = digit + g_Width'(1);
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == '0) begin
                        digit = DIGIT_MAX;
                    end else begin
                        digit = digit - g_Width'(1);
                        carry = 1'b0;
                    end
                end
            end
            stepped_w[i*g_Width +: g_Width] = digit;
        end
        limit_w = carry;
    end

    always_comb begin
        presc_d = presc_q;
        value_d = value_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (i_Clear) begin
            presc_d = '0;
            value_d = '0;
        end else if (i_Load) begin
            presc_d = '0;
            value_d = loaded_w;
        end else if (tick_w) begin
            presc_d = '0;
            tick_d  = 1'b1;
            wrap_d  = limit_w;
`ifdef AUTO_COUNTER_SATURATE_EN
            // A tick at the limit still pulses, but the value is kept.
            value_d = limit_w ? value_q : stepped_w;
`else
            value_d = stepped_w;
`endif
        end else if (i_Enable) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            presc_q <= '0;
            value_q <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            value_q <= value_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_Value = value_q;
    assign o_Tick  = tick_q;
    assign o_Wrap  = wrap_q;

endmodule
